bus_arbiter_2to1: RTL



---
 rtl/bus_arbiter_2to1_if.sv | 26 ++
 rtl/bus_arbiter_2to1.sv | 86 ++++++++
 2 files changed

// File: rtl/bus_arbiter_2to1_if.sv
// Handshake and shared-bus signals between two requesters and the 2:1 bus arbiter.
// Latency: none; this is wiring only.
// Backpressure: requesters hold reqN until they see gntN; there is no stall on bus_data.
interface bus_arbiter_2to1_if;
  logic       req0;
  logic       req1;
  logic [7:0] data0;
  logic [7:0] data1;
  logic       gnt0;
  logic       gnt1;
  logic       sel;
  logic [7:0] bus_data;
  logic       bus_valid;

  // Requester side: drives requests and bytes, observes grants and the bus.
  modport master (
    output req0, req1, data0, data1,
    input  gnt0, gnt1, sel, bus_data, bus_valid
  );

  // Arbiter side.
  modport slave (
    input  req0, req1, data0, data1,
    output gnt0, gnt1, sel, bus_data, bus_valid
  );
endinterface

// File: rtl/bus_arbiter_2to1.sv
// Round-robin 2:1 arbiter for the 8-bit internal bus with a hold limit and registered bus byte.
// Latency: req->gnt 1 cycle; byte driven in a grant cycle appears on bus_data the next cycle.
// Backpressure: a waiting requester stalls on reqN until granted; a holder is preempted after MAX_HOLD cycles.
module bus_arbiter_2to1 #(
  parameter int unsigned MAX_HOLD = 4  // legal range 1..15
) (
  input logic             clk,
  input logic             rst,
  bus_arbiter_2to1_if.slave bus
);

  // One-hot-style encoding so gnt0/gnt1/sel come straight off flops with no decode glitches.
  localparam logic [1:0] IDLE   = 2'b00;
  localparam logic [1:0] GRANT0 = 2'b01;
  localparam logic [1:0] GRANT1 = 2'b10;

  localparam logic [3:0] HOLD_LAST = 4'(MAX_HOLD - 1);

  logic [1:0] state, state_nxt;
  logic       last, last_nxt;
  logic [3:0] hold_cnt, hold_cnt_nxt;

  // Next-state: round-robin tie break, direct handoff on release, preemption at the hold limit.
  always_comb begin
    state_nxt    = state;
    last_nxt     = last;
    hold_cnt_nxt = hold_cnt;

    case (state)
      IDLE: begin
        // On a tie the requester that is not 'last' wins.
        if (bus.req0 && (!bus.req1 || last)) state_nxt = GRANT0;
        else if (bus.req1)                   state_nxt = GRANT1;
      end
      GRANT0: begin
        if (!bus.req0)                               state_nxt = bus.req1 ? GRANT1 : IDLE;
        else if (bus.req1 && hold_cnt == HOLD_LAST)  state_nxt = GRANT1;
      end
      GRANT1: begin
        if (!bus.req1)                               state_nxt = bus.req0 ? GRANT0 : IDLE;
        else if (bus.req0 && hold_cnt == HOLD_LAST)  state_nxt = GRANT0;
      end
      default: state_nxt = IDLE;
    endcase

    // A new tenure restarts the hold count; a continuing one counts up and saturates, so a
    // late-arriving competitor preempts on the very next edge.
    if (state_nxt != state && state_nxt != IDLE) begin
      hold_cnt_nxt = 4'd0;
      last_nxt     = (state_nxt == GRANT1);
    end else if (state_nxt == state && state != IDLE && hold_cnt != HOLD_LAST) begin
      hold_cnt_nxt = hold_cnt + 4'd1;
    end
  end

  // Arbitration state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      last     <= 1'b1;   // requester 0 wins the first tie
      hold_cnt <= 4'd0;
    end else begin
      state    <= state_nxt;
      last     <= last_nxt;
      hold_cnt <= hold_cnt_nxt;
    end
  end

  assign bus.gnt0 = state[0];
  assign bus.gnt1 = state[1];
  assign bus.sel  = state[1];

  // Capture the granted requester's byte at the end of each grant cycle; hold it otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.bus_data  <= 8'h00;
      bus.bus_valid <= 1'b0;
    end else if (state != IDLE) begin
      bus.bus_data  <= state[1] ? bus.data1 : bus.data0;
      bus.bus_valid <= 1'b1;
    end else begin
      bus.bus_valid <= 1'b0;
    end
  end

endmodule
